wb_line_responder: RTL



---
 rtl/wb_line_responder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/wb_line_responder.sv
// Wishbone classic slave backed by a line-addressed memory model.
// One 128-bit line transfer at a time, programmable access latency,
// byte-masked writes, RTY for lines at or beyond DEPTH.
module wb_line_responder #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 128,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                CYC,
  input  logic                STB,
  input  logic                WE,
  input  logic [DATA_W/8-1:0] SEL,
  input  logic [ADDR_W-1:0]   ADR,
  input  logic [DATA_W-1:0]   DAT_M,
  output logic [DATA_W-1:0]   DAT_S,
  output logic                ACK,
  output logic                RTY,
  output logic                busy
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
  // WAIT is skipped entirely for LATENCY=1, so the init value only matters for LATENCY>=2
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, next_state;

  // Line storage; reset never touches it, contents start at zero
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic              req;
  logic [IDX_W-1:0]  idx_l;
  logic              we_l;
  logic              oor_l;
  logic [SEL_W-1:0]  sel_l;
  logic [DATA_W-1:0] dat_l;
  logic [3:0]        cnt;

  logic              oor_live;
  logic              cur_oor;
  logic              cur_we;
  logic [IDX_W-1:0]  cur_idx;
  logic              ack_d;
  logic              rty_d;
  logic              busy_d;
  logic [DATA_W-1:0] dat_d;

  assign req      = CYC & STB;
  assign oor_live = ({1'b0, ADR} >= DEPTH_X);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: accept in IDLE, count or abort in WAIT, single RESP cycle
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req) begin
          next_state = (LATENCY == 1) ? RESP : WAIT;
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (!req) begin
          next_state = IDLE;
        end else if (cnt == 4'd0) begin
          next_state = RESP;
        end else begin
          next_state = WAIT;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch and latency counter; inputs are only sampled on the accept edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_l <= '0;
      we_l  <= 1'b0;
      oor_l <= 1'b0;
      sel_l <= '0;
      dat_l <= '0;
      cnt   <= 4'd0;
    end else if (state == IDLE && req) begin
      idx_l <= ADR[IDX_W-1:0];
      we_l  <= WE;
      oor_l <= oor_live;
      sel_l <= SEL;
      dat_l <= DAT_M;
      cnt   <= CNT_INIT;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end else begin
      cnt <= cnt;
    end
  end

  // Request attributes seen by the output logic: live inputs on the accept edge
  // (needed when LATENCY=1 enters RESP straight from IDLE), latched ones afterwards
  always_comb begin
    if (state == IDLE) begin
      cur_oor = oor_live;
      cur_we  = WE;
      cur_idx = ADR[IDX_W-1:0];
    end else begin
      cur_oor = oor_l;
      cur_we  = we_l;
      cur_idx = idx_l;
    end
  end

  // Output decode: values the registered outputs take for the next cycle
  always_comb begin
    ack_d  = 1'b0;
    rty_d  = 1'b0;
    dat_d  = '0;
    busy_d = (next_state != IDLE);
    if (next_state == RESP) begin
      if (cur_oor) begin
        rty_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        if (!cur_we) begin
          dat_d = mem[cur_idx];
        end else begin
          dat_d = '0;
        end
      end
    end else begin
      dat_d = '0;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ACK   <= 1'b0;
      RTY   <= 1'b0;
      busy  <= 1'b0;
      DAT_S <= '0;
    end else begin
      ACK   <= ack_d;
      RTY   <= rty_d;
      busy  <= busy_d;
      DAT_S <= dat_d;
    end
  end

  // Byte-masked write commit on the edge that ends an in-range write RESP
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && we_l && !oor_l) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (sel_l[i]) begin
          mem[idx_l][8*i +: 8] <= dat_l[8*i +: 8];
        end
      end
    end
  end

endmodule
